// File: rtl/game_tick_ctrl.sv
// game_tick_ctrl: shared prescaler feeding NCH divided tick channels,
// sequenced by an IDLE/RUN/PAUSE FSM. TICK_TOGGLE_EN adds tick_tgl.
module game_tick_ctrl #(
  parameter int CLK_DIV = 4999,
  parameter int PRE_W   = 20,
  parameter int NCH     = 4,
  parameter int DIV_W   = 8,
  parameter int DEF_DIV = 0
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             stop,
  input  logic             pause,
  input  logic             cfg_valid,
  output logic             cfg_ready,
  input  logic [2:0]       cfg_ch,
  input  logic [DIV_W-1:0] cfg_div,
  output logic             base_tick,
  output logic [NCH-1:0]   tick,
  output logic             running,
  output logic             paused
`ifdef TICK_TOGGLE_EN
  ,
  output logic [NCH-1:0]   tick_tgl
`endif
);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_PAUSE = 2'd2
  } state_e;

  localparam logic [PRE_W-1:0] PRE_TC  = PRE_W'(CLK_DIV);
  localparam logic [DIV_W-1:0] DIV_RST = DIV_W'(DEF_DIV);

  state_e             state_q, state_d;
  logic               running_q, running_d;
  logic               paused_q, paused_d;
  logic [PRE_W-1:0]   pre_q, pre_d;
  logic               base_q, base_d;
  logic [NCH-1:0]     tick_q, tick_d;
  logic [DIV_W-1:0]   cnt_q [NCH];
  logic [DIV_W-1:0]   cnt_d [NCH];
  logic [DIV_W-1:0]   div_q [NCH];
  logic [DIV_W-1:0]   div_d [NCH];

  logic run_adv;
  logic to_idle;
  logic wrap;
  logic cfg_fire;

  // Config port only accepts writes while the counters are frozen.
  assign cfg_ready = (state_q != ST_RUN);
  assign cfg_fire  = cfg_valid & cfg_ready;

  assign base_tick = base_q;
  assign tick      = tick_q;
  assign running   = running_q;
  assign paused    = paused_q;

  // Next state: stop beats start beats pause.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_IDLE: begin
        if (start && !stop) state_d = ST_RUN;
      end
      ST_RUN: begin
        if (stop)       state_d = ST_IDLE;
        else if (pause) state_d = ST_PAUSE;
      end
      ST_PAUSE: begin
        if (stop)        state_d = ST_IDLE;
        else if (!pause) state_d = ST_RUN;
      end
      default: state_d = ST_IDLE;
    endcase
    running_d = (state_d == ST_RUN);
    paused_d  = (state_d == ST_PAUSE);
  end

  // Counting happens only on cycles that stay in RUN, so a leaving
  // transition (stop or pause) never produces a pulse or loses a count.
  always_comb begin
    run_adv = (state_q == ST_RUN) && (state_d == ST_RUN);
    to_idle = (state_d == ST_IDLE) && (state_q != ST_IDLE);
    wrap    = run_adv && (pre_q == PRE_TC);
  end

  // Prescaler: wraps at CLK_DIV, cleared on entry to IDLE.
  always_comb begin
    pre_d  = pre_q;
    base_d = 1'b0;
    if (to_idle) begin
      pre_d = '0;
    end else if (run_adv) begin
      if (wrap) begin
        pre_d  = '0;
        base_d = 1'b1;
      end else begin
        pre_d = pre_q + PRE_W'(1);
      end
    end
  end

  // Channel counters advance on each wrap; config writes reload them.
  always_comb begin
    for (int c = 0; c < NCH; c++) begin
      cnt_d[c]  = cnt_q[c];
      div_d[c]  = div_q[c];
      tick_d[c] = 1'b0;
      if (to_idle) begin
        cnt_d[c] = '0;
      end else if (wrap) begin
        if (cnt_q[c] == div_q[c]) begin
          cnt_d[c]  = '0;
          tick_d[c] = 1'b1;
        end else begin
          cnt_d[c] = cnt_q[c] + DIV_W'(1);
        end
      end
      if (cfg_fire && (cfg_ch == 3'(c))) begin
        div_d[c] = cfg_div;
        cnt_d[c] = '0;
      end
    end
  end

  // State, prescaler and channel registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= ST_IDLE;
      running_q <= 1'b0;
      paused_q  <= 1'b0;
      pre_q     <= '0;
      base_q    <= 1'b0;
      tick_q    <= '0;
      for (int c = 0; c < NCH; c++) begin
        cnt_q[c] <= '0;
        div_q[c] <= DIV_RST;
      end
    end else begin
      state_q   <= state_d;
      running_q <= running_d;
      paused_q  <= paused_d;
      pre_q     <= pre_d;
      base_q    <= base_d;
      tick_q    <= tick_d;
      for (int c = 0; c < NCH; c++) begin
        cnt_q[c] <= cnt_d[c];
        div_q[c] <= div_d[c];
      end
    end
  end

`ifdef TICK_TOGGLE_EN
  logic [NCH-1:0] tgl_q, tgl_d;

  assign tick_tgl = tgl_q;

  // Square wave per channel, halved rate of its tick.
  always_comb begin
    tgl_d = tgl_q ^ tick_d;
    if (to_idle) tgl_d = '0;
  end

  // Toggle registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) tgl_q <= '0;
    else        tgl_q <= tgl_d;
  end
`endif

endmodule
